// File: rtl/serial_shifter_if.sv
// Handshake and data bundle for serial_shifter.
// The requester drives the operands and start; the shifter returns status and result.
interface serial_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             cout;

  modport master (output start, op, din, shamt, input busy, done, dout, cout);
  modport slave  (input start, op, din, shamt, output busy, done, dout, cout);
endinterface

// File: rtl/serial_shifter.sv
// Sequential shifter: one bit position per clock through a 4:1 select cell per slice.
// state   | meaning
// S_IDLE  | waiting for start, result held
// S_SHIFT | one shift per edge until count reaches zero
// S_DONE  | result valid for one cycle, start accepted back-to-back

module mux41_1 (
  input  logic [1:0] sel_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       d_i,
  output logic       y_o
);
  always_comb begin
    y_o = a_i;
    case (sel_i)
      2'b00:   y_o = a_i;
      2'b01:   y_o = b_i;
      2'b10:   y_o = c_i;
      default: y_o = d_i;
    endcase
  end
endmodule

module serial_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  serial_shifter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] mux_out;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic b_in, c_in, d_in;
    if (i == 0) begin : g_lsb
      assign b_in = 1'b0;
    end else begin : g_mid_b
      assign b_in = data_q[i-1];
    end
    // The MSB slice feeds zero for logical right and itself for arithmetic right.
    if (i == WIDTH-1) begin : g_msb
      assign c_in = 1'b0;
      assign d_in = data_q[WIDTH-1];
    end else begin : g_mid_cd
      assign c_in = data_q[i+1];
      assign d_in = data_q[i+1];
    end
    mux41_1 u_mux (
      .sel_i (op_q),
      .a_i   (data_q[i]),
      .b_i   (b_in),
      .c_i   (c_in),
      .d_i   (d_in),
      .y_o   (mux_out[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= 2'b00;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          data_d  = bus.din;
          count_d = bus.shamt;
          op_d    = bus.op;
          cout_d  = 1'b0;
          if (bus.shamt == '0 || bus.op == 2'b00) state_d = S_DONE;
          else                                    state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        data_d  = mux_out;
        count_d = count_q - SHW'(1);
        cout_d  = (op_q == 2'b01) ? data_q[WIDTH-1] : data_q[0];
        if (count_q == SHW'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = (state_q == S_DONE);
  assign bus.dout = data_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: per-cycle model comparison plus directed literal checks.
module tb_serial_shifter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_shifter_if #(.WIDTH(W), .SHW(5)) bus ();
  serial_shifter #(.WIDTH(W), .SHW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic         exp_busy = 1'b0, exp_done = 1'b0, exp_cout = 1'b0;
  logic [W-1:0] exp_dout = '0;
  logic [W-1:0] m_din = '0;
  logic [1:0]   m_op = 2'b00;
  int           m_sh = 0, m_k = 0;

  function automatic logic [W-1:0] shf(logic [W-1:0] d, logic [1:0] op, int k);
    case (op)
      2'b01:   return d << k;
      2'b10:   return d >> k;
      2'b11:   return W'($signed(d) >>> k);
      default: return d;
    endcase
  endfunction

  function automatic logic outbit(logic [W-1:0] d, logic [1:0] op, int k);
    if (k == 0 || op == 2'b00) return 1'b0;
    if (op == 2'b01) return d[W-k];
    return d[k-1];
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: after k shift edges the result is simply din shifted by k.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_busy = 1'b0; exp_done = 1'b0; exp_cout = 1'b0; exp_dout = '0;
        m_op = 2'b00; m_k = 0; m_sh = 0;
      end else if (exp_busy) begin
        m_k++;
        exp_dout = shf(m_din, m_op, m_k);
        exp_cout = outbit(m_din, m_op, m_k);
        if (m_k == m_sh) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
        end
      end else if (bus.start) begin
        m_din = bus.din; m_op = bus.op; m_sh = int'(bus.shamt); m_k = 0;
        exp_dout = bus.din; exp_cout = 1'b0;
        exp_busy = !(m_sh == 0 || m_op == 2'b00);
        exp_done = (m_sh == 0 || m_op == 2'b00);
      end else begin
        exp_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_busy", W'(bus.busy), W'(exp_busy));
      chk("cyc_done", W'(bus.done), W'(exp_done));
      chk("cyc_dout", bus.dout, exp_dout);
      chk("cyc_cout", W'(bus.cout), W'(exp_cout));
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] din, input int sh,
                        input logic [W-1:0] xd, input logic xc, input int xlat,
                        input int xbusy, input logic pulse_mid);
    int lat, bc;
    logic seen;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = op; bus.din = din; bus.shamt = 5'(sh);
    @(posedge clk); #2;
    bus.start = 1'b0;
    lat = 0; bc = 0; seen = 1'b0;
    while (!seen && lat < W + 8) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bc++;
      if (bus.done) seen = 1'b1;
      if (pulse_mid && lat == 2 && !seen) begin
        #1;
        bus.start = 1'b1; bus.op = 2'($urandom_range(1, 3));
        bus.din = $urandom; bus.shamt = 5'($urandom_range(1, 31));
        @(posedge clk); #2;
        bus.start = 1'b0;
      end
    end
    chk("done_seen", W'(seen), W'(1));
    chk("latency", W'(lat), W'(xlat));
    chk("busy_cycles", W'(bc), W'(xbusy));
    chk("dout", bus.dout, xd);
    chk("cout", W'(bus.cout), W'(xc));
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < W + 8 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    logic [1:0] op;
    logic [W-1:0] din;
    int sh;
    bus.start = 1'b0; bus.op = 2'b00; bus.din = '0; bus.shamt = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_dout", bus.dout, W'(0));
    chk("rst_cout", W'(bus.cout), W'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    run_op(2'b01, 32'h0000_0001, 4,  32'h0000_0010, 1'b0, 5,  4,  1'b0);
    run_op(2'b10, 32'h8000_0001, 1,  32'h4000_0000, 1'b1, 2,  1,  1'b0);
    run_op(2'b11, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0, 32, 31, 1'b0);
    run_op(2'b11, 32'h7FFF_FFFF, 31, 32'h0000_0000, 1'b1, 32, 31, 1'b0);
    run_op(2'b01, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 1'b0, 1,  0,  1'b0);
    run_op(2'b00, 32'h1234_ABCD, 7,  32'h1234_ABCD, 1'b0, 1,  0,  1'b0);
    run_op(2'b01, 32'h0000_0003, 6,  32'h0000_00C0, 1'b0, 7,  6,  1'b1);

    // Back-to-back: start stays high through SHIFT and is taken again in DONE.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = 2'b01; bus.din = 32'h0000_0001; bus.shamt = 5'd3;
    @(posedge clk); #2;
    bus.op = 2'b10; bus.din = 32'h0000_00F0; bus.shamt = 5'd4;
    wait_done(seen);
    chk("b2b_first_seen", W'(seen), W'(1));
    chk("b2b_first_dout", bus.dout, 32'h0000_0008);
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_done_drop", W'(bus.done), W'(0));
    chk("b2b_busy_again", W'(bus.busy), W'(1));
    wait_done(seen);
    chk("b2b_second_seen", W'(seen), W'(1));
    chk("b2b_second_dout", bus.dout, 32'h0000_000F);
    chk("b2b_second_cout", W'(bus.cout), W'(0));

    // Asynchronous abort in cycle 3 of a shll by 10.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = 2'b01; bus.din = 32'h1234_5678; bus.shamt = 5'd10;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_done", W'(bus.done), W'(0));
    chk("abort_dout", bus.dout, W'(0));
    chk("abort_cout", W'(bus.cout), W'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    run_op(2'b01, 32'h0000_0001, 2, 32'h0000_0004, 1'b0, 3, 2, 1'b0);

    for (int t = 0; t < 150; t++) begin
      op  = 2'($urandom_range(0, 3));
      din = $urandom;
      sh  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      run_op(op, din, sh, shf(din, op, (op == 2'b00) ? 0 : sh), outbit(din, op, sh),
             (op == 2'b00 || sh == 0) ? 1 : sh + 1,
             (op == 2'b00 || sh == 0) ? 0 : sh,
             (sh >= 3 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
